// File: rtl/frame_sched_pkg.sv
// Shared constants and FSM encoding for the frame scheduler.
`timescale 1ns/1ps
package frame_sched_pkg;
    localparam int FRAME_LEN = 16;  // samples per frame
    localparam int IDX_W     = 4;   // sample index / frequency bin width
    localparam int CNT_W     = 8;   // frame_cnt width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FFT_RUN = 2'd1,
        ANA_RUN = 2'd2
    } state_e;
endpackage

// File: rtl/frame_sched_if.sv
// Bundle of the sample stream, FFT/Analysis handshake and status signals.
`timescale 1ns/1ps
interface frame_sched_if import frame_sched_pkg::*; #(
    parameter int DW = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DW-1:0]             in_data;
    logic [FRAME_LEN*DW-1:0]   frame_data;
    logic                      fft_start;
    logic                      fft_done;
    logic                      ana_start;
    logic                      ana_done;
    logic [IDX_W-1:0]          ana_freq;
    logic [IDX_W-1:0]          freq_out;
    logic                      freq_valid;
    logic [CNT_W-1:0]          frame_cnt;
    logic                      all_done;
    logic                      err;

    // Scheduler side
    modport slave (
        input  in_valid, in_data, fft_done, ana_done, ana_freq,
        output in_ready, frame_data, fft_start, ana_start, freq_out,
               freq_valid, frame_cnt, all_done, err
    );

    // Environment side (sample source, FFT and Analysis engines)
    modport master (
        output in_valid, in_data, fft_done, ana_done, ana_freq,
        input  in_ready, frame_data, fft_start, ana_start, freq_out,
               freq_valid, frame_cnt, all_done, err
    );
endinterface

// File: rtl/frame_sched_pingpong_buf.sv
// Two-bank ping-pong frame store: the writer fills one bank while the
// reader side presents the other bank in parallel on frame_data.
`timescale 1ns/1ps
module frame_sched_pingpong_buf import frame_sched_pkg::*; #(
    parameter int DW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    input  logic [DW-1:0]           in_data_i,
    output logic                    in_ready_o,
    input  logic                    hold_i,       // stop accepting (all frames done)
    input  logic                    release_i,    // free the read bank and advance
    output logic                    rd_bank_o,
    output logic [1:0]              bank_full_o,
    output logic [FRAME_LEN*DW-1:0] frame_data_o
);
    logic [DW-1:0]    mem_q [2][FRAME_LEN];
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             rd_bank_q, rd_bank_d;
    logic             accept;

    assign in_ready_o  = !bank_full_q[wr_bank_q] && !hold_i;
    assign accept      = in_valid_i && in_ready_o;
    assign rd_bank_o   = rd_bank_q;
    assign bank_full_o = bank_full_q;

    // Next-state: writer fill/flip and reader release; they always touch
    // different banks, so both updates of bank_full apply together.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        bank_full_d = bank_full_q;
        rd_bank_d   = rd_bank_q;
        if (accept) begin
            if (wr_ptr_q == IDX_W'(FRAME_LEN - 1)) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                wr_ptr_d               = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
            end
        end
        if (release_i) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            bank_full_q <= 2'b00;
            rd_bank_q   <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            bank_full_q <= bank_full_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    // Sample storage; contents need no reset since bank_full gates use
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_bank_q][wr_ptr_q] <= in_data_i;
        end
    end

    // Whole read bank presented in parallel for the FFT to capture
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_frame
            assign frame_data_o[gi*DW +: DW] = mem_q[rd_bank_q][gi];
        end
    endgenerate
endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: buffers samples into frames and sequences FFT then
// Analysis per frame, with a watchdog that aborts a stalled run.
`timescale 1ns/1ps
module frame_sched import frame_sched_pkg::*; #(
    parameter int DW         = 16,
    parameter int NUM_FRAMES = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    frame_sched_if.slave  bus
);
    localparam int               WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(NUM_FRAMES);

    state_e           state_q;
    logic [WD_W-1:0]  wd_q;
    logic             fft_start_q;
    logic             ana_start_q;
    logic             freq_valid_q;
    logic [IDX_W-1:0] freq_out_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             all_done_q;
    logic             err_q;

    logic             rd_bank;
    logic [1:0]       bank_full;
    logic             rd_full;
    logic             wd_expired;
    logic             release_pulse;
    logic [CNT_W-1:0] cnt_inc;

    frame_sched_pingpong_buf #(.DW(DW)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (bus.in_valid),
        .in_data_i    (bus.in_data),
        .in_ready_o   (bus.in_ready),
        .hold_i       (all_done_q),
        .release_i    (release_pulse),
        .rd_bank_o    (rd_bank),
        .bank_full_o  (bank_full),
        .frame_data_o (bus.frame_data)
    );

    assign rd_full = bank_full[rd_bank];

    // Bank release on FFT completion or FFT abort; saturating frame count
    always_comb begin
        wd_expired    = (wd_q == WD_LIMIT);
        release_pulse = (state_q == FFT_RUN) && (bus.fft_done || wd_expired);
        cnt_inc       = (frame_cnt_q == CNT_LIMIT) ? frame_cnt_q
                                                   : frame_cnt_q + CNT_W'(1);
    end

    // Reader FSM with registered pulses and status; done beats timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            fft_start_q  <= 1'b0;
            ana_start_q  <= 1'b0;
            freq_valid_q <= 1'b0;
            freq_out_q   <= '0;
            frame_cnt_q  <= '0;
            all_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            fft_start_q  <= 1'b0;
            ana_start_q  <= 1'b0;
            freq_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (rd_full && !all_done_q) begin
                        fft_start_q <= 1'b1;
                        state_q     <= FFT_RUN;
                    end
                end
                FFT_RUN: begin
                    if (bus.fft_done) begin
                        ana_start_q <= 1'b1;
                        wd_q        <= '0;
                        state_q     <= ANA_RUN;
                    end else if (wd_expired) begin
                        err_q       <= 1'b1;
                        frame_cnt_q <= cnt_inc;
                        all_done_q  <= all_done_q || (cnt_inc == CNT_LIMIT);
                        wd_q        <= '0;
                        state_q     <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ANA_RUN: begin
                    if (bus.ana_done) begin
                        freq_out_q   <= bus.ana_freq;
                        freq_valid_q <= 1'b1;
                        frame_cnt_q  <= cnt_inc;
                        all_done_q   <= all_done_q || (cnt_inc == CNT_LIMIT);
                        wd_q         <= '0;
                        state_q      <= IDLE;
                    end else if (wd_expired) begin
                        err_q       <= 1'b1;
                        frame_cnt_q <= cnt_inc;
                        all_done_q  <= all_done_q || (cnt_inc == CNT_LIMIT);
                        wd_q        <= '0;
                        state_q     <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: begin
                    wd_q    <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.fft_start  = fft_start_q;
    assign bus.ana_start  = ana_start_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.freq_out   = freq_out_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.all_done   = all_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: two instances share the stimulus, one
// with default parameters and one with TIMEOUT=10 / NUM_FRAMES=2.
`timescale 1ns/1ps
module tb_frame_sched;
    import frame_sched_pkg::*;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_sched_if #(.DW(DW)) ifa ();
    frame_sched_if #(.DW(DW)) ifb ();

    frame_sched #(.DW(DW), .NUM_FRAMES(8), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    frame_sched #(.DW(DW), .NUM_FRAMES(2), .TIMEOUT(10)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data  = '0;
    logic             fft_done = 1'b0;
    logic             ana_done = 1'b0;
    logic [IDX_W-1:0] ana_freq = '0;
    logic             sel      = 1'b0;

    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifa.in_data  = in_data;   assign ifb.in_data  = in_data;
    assign ifa.fft_done = fft_done;  assign ifb.fft_done = fft_done;
    assign ifa.ana_done = ana_done;  assign ifb.ana_done = ana_done;
    assign ifa.ana_freq = ana_freq;  assign ifb.ana_freq = ana_freq;

    wire                    in_ready   = sel ? ifb.in_ready   : ifa.in_ready;
    wire [FRAME_LEN*DW-1:0] frame_data = sel ? ifb.frame_data : ifa.frame_data;
    wire                    fft_start  = sel ? ifb.fft_start  : ifa.fft_start;
    wire                    ana_start  = sel ? ifb.ana_start  : ifa.ana_start;
    wire [IDX_W-1:0]        freq_out   = sel ? ifb.freq_out   : ifa.freq_out;
    wire                    freq_valid = sel ? ifb.freq_valid : ifa.freq_valid;
    wire [CNT_W-1:0]        frame_cnt  = sel ? ifb.frame_cnt  : ifa.frame_cnt;
    wire                    all_done   = sel ? ifb.all_done   : ifa.all_done;
    wire                    err        = sel ? ifb.err        : ifa.err;

    int checks   = 0;
    int failures = 0;

    // Event counters on the selected instance, sampled mid-cycle
    int fs_cnt = 0, as_cnt = 0, fv_cnt = 0, acc_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (fft_start)             fs_cnt  <= fs_cnt + 1;
            if (ana_start)             as_cnt  <= as_cnt + 1;
            if (in_valid && in_ready)  acc_cnt <= acc_cnt + 1;
            if (freq_valid) begin
                fv_cnt <= fv_cnt + 1;
                $display("[%0t] frame reported: freq=%0d frame_cnt=%0d", $time, freq_out, frame_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic s);
        sel = s; in_valid = 0; in_data = '0; fft_done = 0; ana_done = 0; ana_freq = '0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    // Wait for a pulse: 0=fft_start 1=ana_start 2=freq_valid
    task automatic wait_sig(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((which == 0 && fft_start === 1'b1) || (which == 1 && ana_start === 1'b1) ||
                (which == 2 && freq_valid === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Push n samples first..first+n-1 honouring in_ready; gives up on a long stall
    task automatic feed(input int first, input int n, input int max_wait, output int sent);
        sent = 0;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            in_valid = 1'b1; in_data = DW'(first + i);
            while (in_ready !== 1'b1 && w < max_wait) begin tick(); w++; end
            if (in_ready !== 1'b1) break;
            tick(); sent++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (fft_start !== 1'b0)  begin failures++; $display("FAIL reset_fft_start: got %0b want 0", fft_start); end
        checks++; if (ana_start !== 1'b0)  begin failures++; $display("FAIL reset_ana_start: got %0b want 0", ana_start); end
        checks++; if (freq_valid !== 1'b0) begin failures++; $display("FAIL reset_freq_valid: got %0b want 0", freq_valid); end
        checks++; if (freq_out !== 4'd0)   begin failures++; $display("FAIL reset_freq_out: got %0d want 0", freq_out); end
        checks++; if (frame_cnt !== 8'd0)  begin failures++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (all_done !== 1'b0)   begin failures++; $display("FAIL reset_all_done: got %0b want 0", all_done); end
        checks++; if (err !== 1'b0)        begin failures++; $display("FAIL reset_err: got %0b want 0", err); end
    endtask

    task automatic test_single_frame();
        int fs0, fv0;
        logic [DW-1:0] w;
        do_reset(1'b0);
        fs0 = fs_cnt; fv0 = fv_cnt;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            if (i == 15) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_last: got %0b want 1", in_ready); end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (fft_start !== 1'b0) begin failures++; $display("FAIL single_fft_start_t1: got %0b want 0", fft_start); end
        tick();
        checks++; if (fft_start !== 1'b1) begin failures++; $display("FAIL single_fft_start_t2: got %0b want 1", fft_start); end
        for (int k = 0; k < 16; k++) begin
            w = frame_data[k*DW +: DW];
            checks++; if (w !== DW'(k)) begin failures++; $display("FAIL single_frame_data[%0d]: got %0d want %0d", k, w, k); end
        end
        repeat (5) tick();
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        checks++; if (ana_start !== 1'b1) begin failures++; $display("FAIL single_ana_start: got %0b want 1", ana_start); end
        tick();
        checks++; if (ana_start !== 1'b0) begin failures++; $display("FAIL single_ana_start_pulse: got %0b want 0", ana_start); end
        repeat (19) tick();
        ana_done = 1'b1; ana_freq = 4'd3; tick(); ana_done = 1'b0;
        checks++; if (freq_valid !== 1'b1) begin failures++; $display("FAIL single_freq_valid: got %0b want 1", freq_valid); end
        checks++; if (freq_out !== 4'd3)   begin failures++; $display("FAIL single_freq_out: got %0d want 3", freq_out); end
        checks++; if (frame_cnt !== 8'd1)  begin failures++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
        repeat (6) tick();
        checks++; if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL single_fv_count: got %0d want 1", fv_cnt - fv0); end
        checks++; if (fs_cnt - fs0 !== 1) begin failures++; $display("FAIL single_fs_count: got %0d want 1", fs_cnt - fs0); end
    endtask

    task automatic test_backpressure();
        int acc0, sent;
        bit ok;
        logic [DW-1:0] w;
        do_reset(1'b0);
        acc0 = acc_cnt;
        fork
            feed(0, 48, 300, sent);
            begin
                wait_sig(0, 50, ok);
                checks++; if (!ok) begin failures++; $display("FAIL bp_fft_start1: got none want pulse"); end
                repeat (49) tick();
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %0b want 0", in_ready); end
                checks++; if (acc_cnt - acc0 !== 32) begin failures++; $display("FAIL bp_accepted: got %0d want 32", acc_cnt - acc0); end
                repeat (51) tick();
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_at_done: got %0b want 0", in_ready); end
                fft_done = 1'b1; tick(); fft_done = 1'b0;
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_resume: got %0b want 1", in_ready); end
                repeat (3) tick();
                ana_done = 1'b1; ana_freq = 4'd10; tick(); ana_done = 1'b0;
                checks++; if (freq_out !== 4'd10) begin failures++; $display("FAIL bp_freq1: got %0d want 10", freq_out); end
                wait_sig(0, 50, ok);
                checks++; if (!ok) begin failures++; $display("FAIL bp_fft_start2: got none want pulse"); end
                w = frame_data[0 +: DW];
                checks++; if (w !== 16'd16) begin failures++; $display("FAIL bp_frame2_first: got %0d want 16", w); end
                w = frame_data[15*DW +: DW];
                checks++; if (w !== 16'd31) begin failures++; $display("FAIL bp_frame2_last: got %0d want 31", w); end
                repeat (2) tick(); fft_done = 1'b1; tick(); fft_done = 1'b0;
                repeat (2) tick(); ana_done = 1'b1; ana_freq = 4'd11; tick(); ana_done = 1'b0;
                wait_sig(0, 100, ok);
                checks++; if (!ok) begin failures++; $display("FAIL bp_fft_start3: got none want pulse"); end
                w = frame_data[0 +: DW];
                checks++; if (w !== 16'd32) begin failures++; $display("FAIL bp_frame3_first: got %0d want 32", w); end
                fft_done = 1'b1; tick(); fft_done = 1'b0;
                ana_done = 1'b1; ana_freq = 4'd12; tick(); ana_done = 1'b0;
                checks++; if (frame_cnt !== 8'd3) begin failures++; $display("FAIL bp_frame_cnt: got %0d want 3", frame_cnt); end
            end
        join
        checks++; if (sent !== 48) begin failures++; $display("FAIL bp_sent: got %0d want 48", sent); end
    endtask

    task automatic test_timeout();
        int fv0, as0;
        logic [DW-1:0] w;
        do_reset(1'b1);
        fv0 = fv_cnt; as0 = as_cnt;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            if (i == 17) begin
                checks++; if (fft_start !== 1'b1) begin failures++; $display("FAIL to_fft_start: got %0b want 1", fft_start); end
            end
            if (i == 27) begin
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_early: got %0b want 0", err); end
            end
            if (i == 28) begin
                checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_set: got %0b want 1", err); end
                checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL to_frame_cnt: got %0d want 1", frame_cnt); end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (fv_cnt - fv0 !== 0) begin failures++; $display("FAIL to_no_freq_valid: got %0d want 0", fv_cnt - fv0); end
        checks++; if (as_cnt - as0 !== 0) begin failures++; $display("FAIL to_no_ana_start: got %0d want 0", as_cnt - as0); end
        tick();
        checks++; if (fft_start !== 1'b1) begin failures++; $display("FAIL to_next_fft_start: got %0b want 1", fft_start); end
        w = frame_data[0 +: DW];
        checks++; if (w !== 16'd16) begin failures++; $display("FAIL to_next_frame_data: got %0d want 16", w); end
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        ana_done = 1'b1; ana_freq = 4'd9; tick(); ana_done = 1'b0;
        checks++; if (freq_valid !== 1'b1 || freq_out !== 4'd9) begin failures++; $display("FAIL to_next_report: got valid=%0b freq=%0d want valid=1 freq=9", freq_valid, freq_out); end
        checks++; if (frame_cnt !== 8'd2 || all_done !== 1'b1) begin failures++; $display("FAIL to_final_cnt: got cnt=%0d done=%0b want cnt=2 done=1", frame_cnt, all_done); end
    endtask

    task automatic test_num_frames();
        int fs0, fv0, sent;
        bit ok;
        do_reset(1'b1);
        fs0 = fs_cnt; fv0 = fv_cnt;
        fork
            feed(0, 64, 60, sent);
            begin
                for (int f = 0; f < 2; f++) begin
                    wait_sig(0, 200, ok);
                    checks++; if (!ok) begin failures++; $display("FAIL nf_fft_start%0d: got none want pulse", f); end
                    repeat (3) tick();
                    fft_done = 1'b1; tick(); fft_done = 1'b0;
                    tick();
                    ana_done = 1'b1; ana_freq = IDX_W'(5 + f); tick(); ana_done = 1'b0;
                end
                checks++; if (all_done !== 1'b1)  begin failures++; $display("FAIL nf_all_done: got %0b want 1", all_done); end
                checks++; if (frame_cnt !== 8'd2) begin failures++; $display("FAIL nf_frame_cnt: got %0d want 2", frame_cnt); end
                checks++; if (freq_out !== 4'd6)  begin failures++; $display("FAIL nf_freq_out: got %0d want 6", freq_out); end
                checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL nf_ready_low: got %0b want 0", in_ready); end
                checks++; if (err !== 1'b0)       begin failures++; $display("FAIL nf_err: got %0b want 0", err); end
                repeat (40) tick();
                checks++; if (fs_cnt - fs0 !== 2) begin failures++; $display("FAIL nf_fft_starts: got %0d want 2", fs_cnt - fs0); end
                checks++; if (fv_cnt - fv0 !== 2) begin failures++; $display("FAIL nf_freq_valids: got %0d want 2", fv_cnt - fv0); end
                checks++; if (in_ready !== 1'b0 || all_done !== 1'b1) begin failures++; $display("FAIL nf_sticky: got ready=%0b done=%0b want ready=0 done=1", in_ready, all_done); end
            end
        join
    endtask

    task automatic test_reset_mid();
        int fs0;
        logic [DW-1:0] w;
        do_reset(1'b0);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = DW'(200 + i);
            if (i == 19) fft_done = 1'b1;
            if (i == 20) begin
                fft_done = 1'b0;
                checks++; if (ana_start !== 1'b1) begin failures++; $display("FAIL rm_ana_start: got %0b want 1", ana_start); end
            end
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        fs0 = fs_cnt;
        checks++; if (in_ready !== 1'b1 || fft_start !== 1'b0 || ana_start !== 1'b0 || freq_valid !== 1'b0)
            begin failures++; $display("FAIL rm_pulses: got ready=%0b fs=%0b as=%0b fv=%0b want 1 0 0 0", in_ready, fft_start, ana_start, freq_valid); end
        checks++; if (frame_cnt !== 8'd0 || freq_out !== 4'd0 || all_done !== 1'b0 || err !== 1'b0)
            begin failures++; $display("FAIL rm_status: got cnt=%0d freq=%0d done=%0b err=%0b want 0 0 0 0", frame_cnt, freq_out, all_done, err); end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = DW'(300 + i); tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (fft_start !== 1'b1) begin failures++; $display("FAIL rm_fft_start: got %0b want 1", fft_start); end
        w = frame_data[0 +: DW];
        checks++; if (w !== 16'd300) begin failures++; $display("FAIL rm_frame_data: got %0d want 300", w); end
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        ana_done = 1'b1; ana_freq = 4'd7; tick(); ana_done = 1'b0;
        checks++; if (freq_out !== 4'd7 || frame_cnt !== 8'd1) begin failures++; $display("FAIL rm_report: got freq=%0d cnt=%0d want freq=7 cnt=1", freq_out, frame_cnt); end
        repeat (10) tick();
        checks++; if (fs_cnt - fs0 !== 1) begin failures++; $display("FAIL rm_discarded: got %0d fft_starts want 1", fs_cnt - fs0); end
    endtask

    task automatic test_spurious();
        int as0;
        do_reset(1'b0);
        as0 = as_cnt;
        ana_done = 1'b1; fft_done = 1'b1; ana_freq = 4'd12; tick();
        ana_done = 1'b0; fft_done = 1'b0;
        checks++; if (freq_valid !== 1'b0 || ana_start !== 1'b0 || fft_start !== 1'b0)
            begin failures++; $display("FAIL sp_idle_pulses: got fv=%0b as=%0b fs=%0b want 0 0 0", freq_valid, ana_start, fft_start); end
        tick();
        checks++; if (freq_out !== 4'd0 || frame_cnt !== 8'd0) begin failures++; $display("FAIL sp_idle_status: got freq=%0d cnt=%0d want 0 0", freq_out, frame_cnt); end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = DW'(50 + i); tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (fft_start !== 1'b1) begin failures++; $display("FAIL sp_fft_start: got %0b want 1", fft_start); end
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        checks++; if (ana_start !== 1'b1) begin failures++; $display("FAIL sp_ana_start: got %0b want 1", ana_start); end
        tick();
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        checks++; if (ana_start !== 1'b0 || freq_valid !== 1'b0) begin failures++; $display("FAIL sp_ana_run_ignore: got as=%0b fv=%0b want 0 0", ana_start, freq_valid); end
        ana_done = 1'b1; ana_freq = 4'd4; tick(); ana_done = 1'b0;
        checks++; if (freq_valid !== 1'b1 || freq_out !== 4'd4 || frame_cnt !== 8'd1)
            begin failures++; $display("FAIL sp_report: got fv=%0b freq=%0d cnt=%0d want 1 4 1", freq_valid, freq_out, frame_cnt); end
        tick();
        checks++; if (as_cnt - as0 !== 1) begin failures++; $display("FAIL sp_ana_starts: got %0d want 1", as_cnt - as0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_timeout();
        test_num_frames();
        test_reset_mid();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/frame_sched.md
Name: frame_sched

Overview:
Frame-level scheduler for the frequency analysis system. It sits between the filtered sample stream and the shared FFT/Analysis datapath. Incoming samples are gathered into a 2-bank ping-pong buffer of 16-sample frames. For each full frame it sequences an FFT run and then an Analysis run, reports the peak bin per frame, and raises a sticky completion flag after NUM_FRAMES frames.

Parameters:
DW, 16, sample width in bits
NUM_FRAMES, 8, frames to process before all_done (1..255)
TIMEOUT, 255, max cycles spent waiting in FFT_RUN or ANA_RUN before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
in_data  in  DW  sample
frame_data  out  16*DW  frame being processed; sample k at [k*DW +: DW]
fft_start  out  1  one-cycle pulse: FFT may sample frame_data
fft_done  in  1  one-cycle pulse: FFT finished and has captured frame_data
ana_start  out  1  one-cycle pulse: start Analysis
ana_done  in  1  one-cycle pulse: ana_freq valid
ana_freq  in  4  peak bin index from Analysis
freq_out  out  4  last reported peak bin
freq_valid  out  1  one-cycle pulse with each freq_out update
frame_cnt  out  8  frames completed (reported or aborted)
all_done  out  1  sticky, frame_cnt == NUM_FRAMES
err  out  1  sticky, set on any timeout abort

Behaviour:
- Reset (rst high at a clock edge): wr_bank=0, wr_ptr=0, bank_full=00, rd_bank=0, FSM=IDLE, all pulses 0, freq_out=0, frame_cnt=0, all_done=0, err=0, watchdog=0. Buffer contents are don't-care. Reset mid-operation drops all partial and queued frames.
- Writer:
  - in_ready = !bank_full[wr_bank] && !all_done (combinational).
  - On accept: write mem[wr_bank][wr_ptr], then wr_ptr++.
  - When wr_ptr==15 is accepted: set bank_full[wr_bank], toggle wr_bank, clear wr_ptr to 0.
- Reader FSM:
  - IDLE: if bank_full[rd_bank] && !all_done, pulse fft_start and go to FFT_RUN. frame_data is driven from bank rd_bank continuously.
  - FFT_RUN: on fft_done, clear bank_full[rd_bank], toggle rd_bank, pulse ana_start, go to ANA_RUN.
  - ANA_RUN: on ana_done, register freq_out<=ana_freq, pulse freq_valid, increment frame_cnt, go to IDLE.
  - Timeout in FFT_RUN: if the watchdog reaches TIMEOUT with no fft_done, set err, clear bank_full[rd_bank], toggle rd_bank, increment frame_cnt (no freq_valid), go to IDLE.
  - Timeout in ANA_RUN: same as FFT_RUN, except no bank action.
  - The watchdog clears on every state entry.
  - fft_done/ana_done arriving in any other state are ignored.
- Latency:
  - Accepting the 16th sample at cycle t → fft_start high at cycle t+2.
  - fft_done at cycle t → ana_start at cycle t+1.
  - ana_done at cycle t → freq_valid and freq_out at cycle t+1.
  - Back-to-back frames: IDLE re-checks the next bank in the cycle after freq_valid.
- Simultaneous events:
  - Writer set and reader clear of bank_full always target different banks. Both must take effect in the same cycle.
  - If fft_done coincides with a timeout, the done wins.
- Full condition: both banks full → in_ready=0 until fft_done frees a bank.
- all_done rises in the cycle frame_cnt reaches NUM_FRAMES and stays high until rst. While it is high, no new fft_start is issued and in_ready=0.
- frame_cnt saturates at NUM_FRAMES.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, FFT_RUN, ANA_RUN);
  - the FRAME_LEN=16 and IDX_W=4 constants;
  - the frame_cnt width.
- One natural sub-module: pingpong_buf. It holds the 2x16xDW storage, wr_bank/wr_ptr/bank_full, the in_ready logic and the frame_data mux. It exposes release and rd_bank to the FSM.

Test Plan:
- 16 samples 0..15 on consecutive cycles with fft_done 5 cycles after fft_start and ana_done(freq=3) 20 cycles after ana_start → fft_start 2 cycles after last accept; frame_data[k]=k; freq_valid once with freq_out=3; frame_cnt=1.
- Stream 48 samples continuously with fft_done withheld 100 cycles → in_ready drops after sample 32 (both banks full). It resumes the cycle after fft_done. Bank order is preserved (frame_data of frame 2 starts at sample 16).
- fft_done never arrives, TIMEOUT=10 → err=1 at fft_start+11 cycles; frame_cnt=1; no freq_valid; next full bank starts FFT normally.
- NUM_FRAMES=2, feed 64 samples → exactly two freq_valid pulses. all_done=1 after the second; in_ready=0 thereafter; no third fft_start.
- rst asserted for 1 cycle during ANA_RUN with one bank full → all outputs return to reset values; the held frame is discarded; the next 16 samples produce a normal frame.
- Spurious ana_done in IDLE and fft_done in ANA_RUN → ignored; no state change, no freq_valid.
